// File: rtl/ppu_compose.sv
// Two-stage PPU pixel compositor: merges background and prioritised sprite pixels,
// tracks sprite-0 hit (enabled by `define PPU_SPR0_HIT_EN) and muxes the VRAM address bus.
module ppu_compose #(
    parameter int NUM_SPR         = 8,
    parameter int PIX_W           = 4,
    parameter int X_W             = 10,
    parameter int Y_W             = 10,
    parameter int SPR_FETCH_START = 256,
    parameter int SPR_FETCH_END   = 320,
    parameter int PRERENDER_LINE  = 261
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [X_W-1:0]           x_idx,
    input  logic [Y_W-1:0]           scanline,
    input  logic                     show_bg,
    input  logic                     show_spr,
    input  logic                     bg_left_en,
    input  logic                     spr_left_en,
    input  logic [PIX_W-1:0]         bg_pixel,
    input  logic [NUM_SPR*PIX_W-1:0] spr_pixel,
    input  logic [NUM_SPR-1:0]       spr_behind,
    input  logic                     spr0_present,
    input  logic [15:0]              bg_VRAM_addr,
    input  logic [15:0]              spr_VRAM_addr,
    output logic [15:0]              VRAM_addr,
    output logic [PIX_W:0]           pixel,
    output logic                     pixel_valid,
    output logic                     spr0_hit
);

    localparam logic [X_W-1:0] LEFT_COL_END = X_W'(8);
    localparam logic [X_W-1:0] VIS_X_END    = X_W'(256);
    localparam logic [Y_W-1:0] VIS_Y_END    = Y_W'(240);
    localparam logic [X_W-1:0] FETCH_LO     = X_W'(SPR_FETCH_START);
    localparam logic [X_W-1:0] FETCH_HI     = X_W'(SPR_FETCH_END);

    // ---------------------------------------------------------------
    // Input-side masking and opacity
    // ---------------------------------------------------------------
    logic               left_col;
    logic               bg_on;
    logic               spr_on;
    logic               bg_opq;
    logic [NUM_SPR-1:0] spr_opq;
    logic               vis;

    assign left_col = (x_idx < LEFT_COL_END);
    assign bg_on    = show_bg  & ~(left_col & ~bg_left_en);
    assign spr_on   = show_spr & ~(left_col & ~spr_left_en);
    assign bg_opq   = bg_on & (|bg_pixel[1:0]);
    assign vis      = (x_idx < VIS_X_END) && (scanline < VIS_Y_END);

    generate
        for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_spr_opq
            assign spr_opq[gi] = spr_on & (|spr_pixel[gi*PIX_W +: 2]);
        end
    endgenerate

    // Lowest index wins: scan downwards so the last hit is the highest priority.
    logic [PIX_W-1:0] win_pix;
    logic             win_behind;

    always_comb begin
        win_pix    = '0;
        win_behind = 1'b0;
        for (int k = NUM_SPR - 1; k >= 0; k--) begin
            if (spr_opq[k]) begin
                win_pix    = spr_pixel[k*PIX_W +: PIX_W];
                win_behind = spr_behind[k];
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 1 registers. Masked-out sources are stored as 0 so stage 2
    // can rederive opacity from the low bits alone.
    // ---------------------------------------------------------------
    logic [PIX_W-1:0] s1_spr_pix_reg;
    logic             s1_spr_behind_reg;
    logic [PIX_W-1:0] s1_bg_pix_reg;
    logic             s1_vis_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_spr_pix_reg    <= '0;
            s1_spr_behind_reg <= 1'b0;
            s1_bg_pix_reg     <= '0;
            s1_vis_reg        <= 1'b0;
        end else begin
            s1_spr_pix_reg    <= win_pix;
            s1_spr_behind_reg <= win_behind;
            s1_bg_pix_reg     <= bg_opq ? bg_pixel : '0;
            s1_vis_reg        <= vis;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: result selection
    // ---------------------------------------------------------------
    logic           s2_spr_opq;
    logic           s2_bg_opq;
    logic [PIX_W:0] pixel_next;
    logic [PIX_W:0] pixel_reg;
    logic           pixel_valid_reg;

    assign s2_spr_opq = |s1_spr_pix_reg[1:0];
    assign s2_bg_opq  = |s1_bg_pix_reg[1:0];

    always_comb begin
        pixel_next = '0;
        if (s1_vis_reg) begin
            if (s2_spr_opq && (!s1_spr_behind_reg || !s2_bg_opq)) begin
                pixel_next = {1'b1, s1_spr_pix_reg};
            end else if (s2_bg_opq) begin
                pixel_next = {1'b0, s1_bg_pix_reg};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_reg       <= '0;
            pixel_valid_reg <= 1'b0;
        end else begin
            pixel_reg       <= pixel_next;
            pixel_valid_reg <= s1_vis_reg;
        end
    end

    assign pixel       = pixel_reg;
    assign pixel_valid = pixel_valid_reg;

    // ---------------------------------------------------------------
    // Sprite-0 hit
    // ---------------------------------------------------------------
`ifdef PPU_SPR0_HIT_EN
    logic s1_spr0_cand_reg;
    logic s1_x_last_reg;
    logic hit_clear;
    logic hit_set;
    logic spr0_hit_reg;
    logic spr0_hit_next;

    // Channel 0 counts regardless of whether it won or sits behind the background.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_spr0_cand_reg <= 1'b0;
            s1_x_last_reg    <= 1'b0;
        end else begin
            s1_spr0_cand_reg <= spr0_present & spr_opq[0] & bg_opq;
            s1_x_last_reg    <= (x_idx == X_W'(255));
        end
    end

    assign hit_clear = (scanline == Y_W'(PRERENDER_LINE)) && (x_idx == X_W'(1));
    assign hit_set   = s1_vis_reg & s1_spr0_cand_reg & ~s1_x_last_reg;

    always_comb begin
        spr0_hit_next = spr0_hit_reg;
        if (hit_clear) begin
            spr0_hit_next = 1'b0;
        end else if (hit_set) begin
            spr0_hit_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spr0_hit_reg <= 1'b0;
        end else begin
            spr0_hit_reg <= spr0_hit_next;
        end
    end

    assign spr0_hit = spr0_hit_reg;
`else
    logic unused_spr0_inputs;
    assign unused_spr0_inputs = &{1'b0, spr0_present};
    assign spr0_hit           = 1'b0;
`endif

    // ---------------------------------------------------------------
    // VRAM bus arbitration, combinational so the switch lands on the boundary dot
    // ---------------------------------------------------------------
    always_comb begin
        VRAM_addr = bg_VRAM_addr;
        if ((x_idx >= FETCH_LO) && (x_idx < FETCH_HI)) begin
            VRAM_addr = spr_VRAM_addr;
        end
    end

endmodule

// File: doc/ppu_compose.md
# ppu_compose

Parametrised pixel compositor for the PPU render path. It merges the background pixel and up to `NUM_SPR` sprite channel pixels into one palette address using a 2-stage pipeline. It applies PPUMASK enables and left-column masking, detects sprite-0 hit as a sticky flag, and arbitrates the shared VRAM address bus between the background and sprite fetch units. It sits between `ppu_bg`/`ppu_spr` and the palette RAM lookup.

## Interface
Reset is asynchronous and active-low.

**Parameters**
- `NUM_SPR`, 8: number of sprite channels. Channel index is priority; 0 is highest.
- `PIX_W`, 4: palette-index bits per source pixel (2 pattern + 2 attribute).
- `X_W`, 10: width of `x_idx`.
- `Y_W`, 10: width of `scanline`.
- `SPR_FETCH_START`, 256: first dot of the sprite fetch window.
- `SPR_FETCH_END`, 320: first dot after the sprite fetch window.
- `PRERENDER_LINE`, 261: pre-render scanline.

**Ports**
- `clk` in 1: PPU dot clock.
- `reset` in 1: asynchronous, active-low.
- `x_idx` in X_W: current dot.
- `scanline` in Y_W: current line.
- `show_bg` in 1: PPUMASK background enable.
- `show_spr` in 1: PPUMASK sprite enable.
- `bg_left_en` in 1: show background in dots 0-7.
- `spr_left_en` in 1: show sprites in dots 0-7.
- `bg_pixel` in PIX_W: background pixel for `x_idx`.
- `spr_pixel` in NUM_SPR*PIX_W: channel k occupies bits [k*PIX_W +: PIX_W].
- `spr_behind` in NUM_SPR: per-channel OAM priority bit (1 = behind background).
- `spr0_present` in 1: channel 0 holds OAM sprite 0 on this line.
- `bg_VRAM_addr` in 16: background fetch address.
- `spr_VRAM_addr` in 16: sprite fetch address.
- `VRAM_addr` out 16: arbitrated VRAM address.
- `pixel` out PIX_W+1: palette address; MSB 1 = sprite palette.
- `pixel_valid` out 1: `pixel` corresponds to a visible dot.
- `spr0_hit` out 1: sticky sprite-0 hit flag.

## Operation
- **Opacity.** A source is opaque when its low 2 bits are nonzero.
- **Masking.** A source is forced transparent when any of the following holds:
  - its show enable is 0;
  - `x_idx` < 8 and its left enable is 0.
- **Stage 1 (registered).**
  - Per-channel masked opacity.
  - Priority encode: select the lowest-index opaque sprite channel. Register its pixel, its `spr_behind`, and whether it is channel 0.
  - Register the masked background pixel.
  - Register `vis` = (`x_idx` < 256 && `scanline` < 240).
- **Stage 2 (registered), result selection.**
  - Sprite opaque and (behind=0 or background transparent): `pixel` = {1, spr}.
  - Otherwise, background opaque: `pixel` = {0, bg}.
  - Otherwise: `pixel` = 0 (universal backdrop).
  - If `vis`=0: `pixel` = 0.
  - `pixel_valid` = stage-1 `vis`.
- **Sprite-0 hit.**
  - Set in stage 2 when all of the following hold: `vis`, `spr0_present` (pipelined), channel 0 masked-opaque (independent of winner or `spr_behind`), background masked-opaque, and pipelined x ≠ 255.
  - Cleared when `scanline` = PRERENDER_LINE and `x_idx` = 1. Clear has priority over set in the same cycle.
  - Holds otherwise.
- **VRAM arbitration (combinational).**
  - `VRAM_addr` = `spr_VRAM_addr` when SPR_FETCH_START ≤ `x_idx` < SPR_FETCH_END.
  - Otherwise `VRAM_addr` = `bg_VRAM_addr`.
- **Sprite ties.** Several opaque sprites: the lowest index wins even if it is behind and the background is opaque. In that case the background shows and higher-index sprites do not show through.

## Timing
- Latency from `x_idx`/source inputs to `pixel`/`pixel_valid`: 2 clocks. Throughput: 1 pixel/clock, no stalls.
- `spr0_hit` rises 2 clocks after the qualifying input dot.
- `VRAM_addr` has 0-cycle latency. The switch occurs in the same cycle `x_idx` enters or leaves the window.
- **Reset.** All pipeline registers are 0: `pixel`=0, `pixel_valid`=0, `spr0_hit`=0. Reset mid-frame discards in-flight pixels; the next 2 outputs after release are 0/invalid.
- PPUMASK changes take effect on the dot sampled in the same cycle (stage-1 input).

## Configuration
- Macro: `PPU_SPR0_HIT_EN`.
- **Defined:** sprite-0 hit logic as described above.
- **Undefined:** hit pipeline bits are not generated and `spr0_hit` is tied to 0. All other behaviour is identical.

## Test plan
- **Basic compositing.** Reset, then line 10, x=20, bg=4'h5, all sprites 0, both shows 1. Expect `pixel`=5'h05 and `pixel_valid`=1 two clocks later.
- **Sprite priority.** Channel 3=4'h6 (front) and channel 5=4'h9, bg=4'h5. Expect 5'h16.
- **Behind sprite.** Channel 0 behind=1, spr=4'h6, bg=4'h5 → 5'h05. Then bg=4'h4 (transparent) → 5'h16.
- **Left-column mask.** x=3, `bg_left_en`=0, `spr_left_en`=1, bg=4'h5, spr0=4'h6 behind=1. Expect 5'h16 and no `spr0_hit`. Same stimulus at x=8: expect 5'h05 and `spr0_hit`=1.
- **Sprite-0 hit edges.** No hit at x=255 or at line 240. Flag stays 1 until line 261 dot 1, then drops to 0. Build without the macro: `spr0_hit` stays 0 throughout.
- **VRAM arbitration.** x=255 → bg address; x=256 and x=319 → sprite address; x=320 → bg address. Assert reset at x=100: `pixel`=0 and `pixel_valid`=0 immediately.
